// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the display-share arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int DISP_W    = 16;
  localparam int DWELL_DEF = 25000000;
  localparam int MAX_REQ   = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_share_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set, non-excluded
//               request found scanning upward from START_I with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  excl_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] win_o,
  output logic             found_o
);

  logic [NREQ-1:0] w_cand;
  int              w_idx;

  assign w_cand = req_i & ~excl_i;

  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(start_i) + k) % NREQ;
      if (!found_o && w_cand[w_idx]) begin
        found_o = 1'b1;
        win_o   = IDX_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_share_arb.sv
// ============================================================================
// Module      : disp_share_arb
// Description : Round-robin time-share of the 4-digit display between NREQ
//               value sources with a minimum dwell; feeds the digit scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_share_arb
  import disp_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DISP_W = disp_pkg::DISP_W,
  parameter int DWELL  = disp_pkg::DWELL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic [DISP_W-1:0]      number,
  output logic                   active
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(NREQ - 1);

  state_e             state_q,  state_d;
  logic [IDX_W-1:0]   ptr_q,    ptr_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [NREQ-1:0]    grant_q,  grant_d;
  logic [NREQ-1:0]    ack_q,    ack_d;
  logic [DISP_W-1:0]  number_q, number_d;
  logic               active_q, active_d;

  logic [DISP_W-1:0]  w_data [NREQ];
  logic [IDX_W-1:0]   w_start;
  logic [NREQ-1:0]    w_excl;
  logic [NREQ-1:0]    w_oh_ptr;
  logic [NREQ-1:0]    w_oh_win;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic               w_arb;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_data[i] = data[i*DISP_W +: DISP_W];
  end

  // In SHOW the pointer always equals the granted index, so one picker serves both states.
  assign w_start  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  assign w_oh_ptr = NREQ'(onehot(3'(ptr_q)));
  assign w_oh_win = NREQ'(onehot(3'(w_win)));
  assign w_excl   = (state_q == SHOW) ? w_oh_ptr : '0;
  assign w_arb    = (cnt_q == DWELL_LAST) || !req[ptr_q];

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .excl_i  (w_excl),
    .start_i (w_start),
    .win_o   (w_win),
    .found_o (w_found)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ack_d    = '0;
    number_d = number_q;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d  = SHOW;
          ptr_d    = w_win;
          cnt_d    = '0;
          grant_d  = w_oh_win;
          ack_d    = w_oh_win;
          number_d = w_data[w_win];
          active_d = 1'b1;
        end
      end
      SHOW: begin
        if (!w_arb) begin
          cnt_d    = cnt_q + 1'b1;
          number_d = w_data[ptr_q];
        end else if (w_found) begin
          ptr_d    = w_win;
          cnt_d    = '0;
          grant_d  = w_oh_win;
          ack_d    = w_oh_win;
          number_d = w_data[w_win];
        end else if (req[ptr_q]) begin
          cnt_d    = '0;
          number_d = w_data[ptr_q];
        end else begin
          state_d  = IDLE;
          cnt_d    = '0;
          grant_d  = '0;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_LAST;
      cnt_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      number_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      number_q <= number_d;
      active_q <= active_d;
    end
  end

  assign grant  = grant_q;
  assign ack    = ack_q;
  assign number = number_q;
  assign active = active_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_share_arb.sv
// ============================================================================
// Module      : tb_disp_share_arb
// Description : Directed, scoreboard-checked bench for disp_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_share_arb;

  localparam int NREQ   = 4;
  localparam int DISP_W = 16;
  localparam int DWELL  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DISP_W-1:0] data;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        ack;
  logic [DISP_W-1:0]      number;
  logic                   active;

  typedef struct packed {
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic [DISP_W-1:0] number;
    logic              active;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    tests = 0;
  int    fails = 0;

  disp_share_arb #(
    .NREQ   (NREQ),
    .DISP_W (DISP_W),
    .DWELL  (DWELL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .grant  (grant),
    .ack    (ack),
    .number (number),
    .active (active)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [NREQ-1:0] g, input logic [NREQ-1:0] a,
                      input logic [DISP_W-1:0] n, input logic act);
    exp_t e;
    e.grant  = g;
    e.ack    = a;
    e.number = n;
    e.active = act;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one clock and compare outputs against the oldest expectation.
  task automatic cycle();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests += 3;
    assert (grant === e.grant) else begin
      fails++;
      $error("FAIL %s.grant observed=%b expected=%b", t, grant, e.grant);
    end
    assert (ack === e.ack) else begin
      fails++;
      $error("FAIL %s.ack observed=%b expected=%b", t, ack, e.ack);
    end
    assert (number === e.number) else begin
      fails++;
      $error("FAIL %s.number observed=%h expected=%h", t, number, e.number);
    end
    assert (active === e.active) else begin
      fails++;
      $error("FAIL %s.active observed=%b expected=%b", t, active, e.active);
    end
  endtask

  task automatic set_data(input int idx, input logic [DISP_W-1:0] v);
    data[idx*DISP_W +: DISP_W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push("reset", 4'b0000, 4'b0000, 16'h0000, 1'b0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0]   g;
    logic [DISP_W-1:0] n;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    do_reset();

    // Idle after reset: nothing shown, nothing granted.
    for (int i = 0; i < 10; i++) begin
      push("idle", 4'b0000, 4'b0000, 16'h0000, 1'b0);
      cycle();
    end

    // Single requester: one ack, then held without re-ack across dwell rollover.
    set_data(0, 16'h1234);
    req = 4'b0001;
    push("single_win", 4'b0001, 4'b0001, 16'h1234, 1'b1);
    cycle();
    for (int i = 0; i < 6; i++) begin
      push("single_hold", 4'b0001, 4'b0000, 16'h1234, 1'b1);
      cycle();
    end

    // Two requesters alternate every DWELL cycles.
    do_reset();
    set_data(0, 16'hAAAA);
    set_data(2, 16'hCCCC);
    req = 4'b0101;
    for (int sw = 0; sw < 4; sw++) begin
      g = (sw % 2 == 0) ? 4'b0001 : 4'b0100;
      n = (sw % 2 == 0) ? 16'hAAAA : 16'hCCCC;
      for (int k = 0; k < DWELL; k++) begin
        push("rotate", g, (k == 0) ? g : 4'b0000, n, 1'b1);
        cycle();
      end
    end

    // Early release at count 1 hands over to the pending requester.
    do_reset();
    set_data(0, 16'h1111);
    set_data(1, 16'h2222);
    req = 4'b0001;
    push("early_win0", 4'b0001, 4'b0001, 16'h1111, 1'b1);
    cycle();
    req = 4'b0011;
    push("early_pend", 4'b0001, 4'b0000, 16'h1111, 1'b1);
    cycle();
    req = 4'b0010;
    push("early_switch", 4'b0010, 4'b0010, 16'h2222, 1'b1);
    cycle();
    push("early_hold", 4'b0010, 4'b0000, 16'h2222, 1'b1);
    cycle();

    // Live data follows the granted source only.
    do_reset();
    set_data(2, 16'h0001);
    set_data(0, 16'h0BAD);
    req = 4'b0100;
    push("live_win2", 4'b0100, 4'b0100, 16'h0001, 1'b1);
    cycle();
    set_data(2, 16'h0002);
    push("live_update", 4'b0100, 4'b0000, 16'h0002, 1'b1);
    cycle();
    set_data(3, 16'hDEAD);
    push("other_data", 4'b0100, 4'b0000, 16'h0002, 1'b1);
    cycle();

    // Release with nobody waiting: back to idle, number holds.
    req = 4'b0000;
    push("to_idle", 4'b0000, 4'b0000, 16'h0002, 1'b0);
    cycle();
    push("idle_hold", 4'b0000, 4'b0000, 16'h0002, 1'b0);
    cycle();

    // Pointer is 2, so requester 3 wins next; then reset mid-dwell.
    req = 4'b1001;
    push("win3", 4'b1000, 4'b1000, 16'hDEAD, 1'b1);
    cycle();
    push("dwell3", 4'b1000, 4'b0000, 16'hDEAD, 1'b1);
    cycle();
    do_reset();
    push("post_reset_win0", 4'b0001, 4'b0001, 16'h0BAD, 1'b1);
    cycle();

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
